multicycle_control: RTL and testbench

Main control FSM for the multi-cycle MIPS32 datapath. It sequences each instruction through fetch, decode, execute, memory and write-back, and drives the datapath mux selects and write strobes. It drives the 2-bit `alu_op` consumed by the ALU control decoder, which turns `alu_op` plus `funct` into the 3-bit ALU operation. Memory accesses use a `mem_ready` handshake so that memory latency can vary.

---
 rtl/multicycle_control.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS32 datapath: steps each instruction
// through fetch/decode/execute/memory/write-back and drives the datapath controls.
//
// state   | meaning
// --------+-------------------------------------------------
// FETCH   | read instruction at PC, PC <= PC + 4 (waits mem_ready)
// DECODE  | read registers, precompute branch target
// MEMADR  | ALUOut <= A + sign-extended offset (lw/sw)
// MEMRD   | read data memory at ALUOut (waits mem_ready)
// MEMWB   | rt <= MDR
// MEMWR   | write data memory at ALUOut (waits mem_ready)
// EXEC    | R-type ALU operation
// ALUWB   | rd <= ALUOut
// BRANCH  | beq compare, PC <= ALUOut when zero
// ADDIEX  | A + sign-extended immediate
// ADDIWB  | rt <= ALUOut
// JUMP    | PC <= jump target
module multicycle_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       branch,
   output logic       illegal_op,
   output logic       instr_done,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_ALUWB  = 4'd7,
      ST_BRANCH = 4'd8,
      ST_ADDIEX = 4'd9,
      ST_ADDIWB = 4'd10,
      ST_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_t cur;
   logic   pc_write;

   assign state = cur;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur <= ST_FETCH;
      end else begin
         case (cur)
            ST_FETCH:  if (mem_ready) cur <= ST_DECODE;
            ST_DECODE: begin
               case (opcode)
                  OP_LW, OP_SW: cur <= ST_MEMADR;
                  OP_RTYPE:     cur <= ST_EXEC;
                  OP_BEQ:       cur <= ST_BRANCH;
                  OP_ADDI:      cur <= ST_ADDIEX;
                  OP_J:         cur <= ST_JUMP;
                  default:      cur <= ST_FETCH;
               endcase
            end
            ST_MEMADR: cur <= (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  if (mem_ready) cur <= ST_MEMWB;
            ST_MEMWR:  if (mem_ready) cur <= ST_FETCH;
            ST_EXEC:   cur <= ST_ALUWB;
            ST_ADDIEX: cur <= ST_ADDIWB;
            // 12..15 fall through to default and recover to FETCH
            default:   cur <= ST_FETCH;
         endcase
      end
   end

   always_comb begin
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      pc_write   = 1'b0;
      branch     = 1'b0;
      illegal_op = 1'b0;
      instr_done = 1'b0;
      pc_en      = 1'b0;
      // reset masks every strobe and select, even mid-instruction
      if (rst_n) begin
         case (cur)
            ST_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            ST_DECODE: begin
               alu_src_b = 2'b11;
               case (opcode)
                  OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                  default:                                       illegal_op = 1'b1;
               endcase
            end
            ST_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            ST_MEMRD: begin
               iord     = 1'b1;
               mem_read = 1'b1;
            end
            ST_MEMWB: begin
               mem_to_reg = 1'b1;
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            ST_MEMWR: begin
               iord       = 1'b1;
               mem_write  = 1'b1;
               instr_done = mem_ready;
            end
            ST_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            ST_ALUWB: begin
               reg_dst    = 1'b1;
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            ST_BRANCH: begin
               alu_src_a  = 1'b1;
               alu_op     = 2'b01;
               pc_src     = 2'b01;
               branch     = 1'b1;
               instr_done = 1'b1;
            end
            ST_ADDIEX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            ST_ADDIWB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            ST_JUMP: begin
               pc_src     = 2'b10;
               pc_write   = 1'b1;
               instr_done = 1'b1;
            end
            default: ;
         endcase
         pc_en = pc_write | (branch & zero);
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction step recipes drive a cycle model,
// checked by a vector table, a reset-mid-instruction sequence and random traffic.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
   logic       alu_src_a, pc_en, branch, illegal_op, instr_done;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic [3:0] state;

   int errors = 0;
   int checks = 0;

   localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00, BEQ = 6'h04, ADDI = 6'h08, JMP = 6'h02;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
      .pc_en(pc_en), .branch(branch), .illegal_op(illegal_op), .instr_done(instr_done),
      .state(state)
   );

   always #5 clk = ~clk;

   function automatic logic [21:0] got_word();
      return {state, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
              alu_src_a, alu_src_b, alu_op, pc_src, pc_en, branch, illegal_op, instr_done};
   endfunction

   function automatic bit is_legal(input logic [5:0] op);
      return op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == JMP;
   endfunction

   // Expected controls for one step of an instruction, straight from the per-state tables.
   function automatic logic [21:0] exp_word(input int ph, input logic rdy, input logic z,
                                            input logic [5:0] op);
      logic io, mr, mw, irw, rd, mtr, rw, sa, pce, br, il, dn;
      logic [1:0] sb, aop, ps;
      {io, mr, mw, irw, rd, mtr, rw, sa, pce, br, il, dn} = '0;
      sb = 2'b00; aop = 2'b00; ps = 2'b00;
      case (ph)
         0:  begin mr = 1; sb = 2'b01; irw = rdy; pce = rdy; end
         1:  begin sb = 2'b11; il = !is_legal(op); end
         2:  begin sa = 1; sb = 2'b10; end
         3:  begin io = 1; mr = 1; end
         4:  begin mtr = 1; rw = 1; dn = 1; end
         5:  begin io = 1; mw = 1; dn = rdy; end
         6:  begin sa = 1; aop = 2'b10; end
         7:  begin rd = 1; rw = 1; dn = 1; end
         8:  begin sa = 1; aop = 2'b01; ps = 2'b01; br = 1; dn = 1; pce = z; end
         9:  begin sa = 1; sb = 2'b10; end
         10: begin rw = 1; dn = 1; end
         11: begin ps = 2'b10; pce = 1; dn = 1; end
         default: ;
      endcase
      return {4'(ph), io, mr, mw, irw, rd, mtr, rw, sa, sb, aop, ps, pce, br, il, dn};
   endfunction

   task automatic check(input string name, input logic [21:0] got, input logic [21:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Plays one instruction starting in FETCH; sf/sm = mem_ready-low cycles in FETCH / data access.
   task automatic run_instr(input logic [5:0] op, input logic z, input int sf, input int sm,
                            output int cycles, output int dones, output int ills,
                            output int pces, output int rws);
      int recipe[$];
      int idx = 0, wf = 0, wm = 0, ph;
      logic rdy;
      cycles = 0; dones = 0; ills = 0; pces = 0; rws = 0;
      recipe = '{0, 1};
      case (op)
         LW:   recipe = '{0, 1, 2, 3, 4};
         SW:   recipe = '{0, 1, 2, 5};
         RT:   recipe = '{0, 1, 6, 7};
         BEQ:  recipe = '{0, 1, 8};
         ADDI: recipe = '{0, 1, 9, 10};
         JMP:  recipe = '{0, 1, 11};
         default: ;
      endcase
      while (idx < recipe.size()) begin
         ph = recipe[idx];
         if (ph == 0)                rdy = (wf >= sf);
         else if (ph == 3 || ph == 5) rdy = (wm >= sm);
         else                         rdy = ($urandom_range(0, 1) != 0);
         mem_ready = rdy;
         zero      = (ph == 8) ? z : ($urandom_range(0, 1) != 0);
         opcode    = (ph == 0) ? 6'($urandom) : op;
         @(negedge clk);
         check("step", got_word(), exp_word(ph, rdy, zero, op));
         check("rd_wr_excl", {21'd0, mem_read & mem_write}, 22'd0);
         check("rw_pc_excl", {21'd0, reg_write & pc_en}, 22'd0);
         dones += int'(instr_done);
         ills  += int'(illegal_op);
         pces  += int'(pc_en);
         rws   += int'(reg_write);
         @(posedge clk); #1;
         cycles++;
         if ((ph == 0 || ph == 3 || ph == 5) && !rdy) begin
            if (ph == 0) wf++; else wm++;
         end else begin
            idx++;
         end
         if (cycles > 60) begin
            check_int("cycle_bound", cycles, -1);
            break;
         end
      end
   endtask

   typedef struct {
      logic [5:0] op;
      logic       z;
      int         sf, sm, cyc, done, ill, pce, rw;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int c, d, il, p, r;
      logic [5:0] op;
      vecs = '{
         '{LW,    1'b0, 0, 0, 5, 1, 0, 1, 1},
         '{SW,    1'b0, 0, 3, 7, 1, 0, 1, 0},
         '{BEQ,   1'b1, 0, 0, 3, 1, 0, 2, 0},
         '{BEQ,   1'b0, 0, 0, 3, 1, 0, 1, 0},
         '{RT,    1'b0, 0, 0, 4, 1, 0, 1, 1},
         '{JMP,   1'b0, 0, 0, 3, 1, 0, 2, 0},
         '{6'h3f, 1'b0, 0, 0, 2, 0, 1, 1, 0},
         '{ADDI,  1'b0, 0, 0, 4, 1, 0, 1, 1},
         '{LW,    1'b1, 2, 1, 8, 1, 0, 1, 1},
         '{SW,    1'b0, 0, 0, 4, 1, 0, 1, 0},
         '{BEQ,   1'b1, 3, 0, 6, 1, 0, 2, 0}
      };

      rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = LW;
      @(negedge clk);
      check("reset_outputs", {4'd0, got_word()[17:0]}, 22'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("after_reset", got_word(), exp_word(0, 1'b1, zero, opcode));
      @(posedge clk); #1;
      // that edge took mem_ready=1 in FETCH; realign with a fresh reset
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_instr(vecs[i].op, vecs[i].z, vecs[i].sf, vecs[i].sm, c, d, il, p, r);
         check_int($sformatf("vec%0d_cycles", i), c, vecs[i].cyc);
         check_int($sformatf("vec%0d_done", i), d, vecs[i].done);
         check_int($sformatf("vec%0d_illegal", i), il, vecs[i].ill);
         check_int($sformatf("vec%0d_pc_en", i), p, vecs[i].pce);
         check_int($sformatf("vec%0d_reg_write", i), r, vecs[i].rw);
      end

      // Reset while stalled in MEMRD
      opcode = 6'h15; mem_ready = 1'b1;
      @(posedge clk); #1;
      opcode = LW;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(negedge clk);
      check("memrd_stall", got_word(), exp_word(3, 1'b0, zero, LW));
      @(posedge clk); #1;
      rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1;
      @(negedge clk);
      check("reset_mid_memrd", got_word(), {4'd3, 18'd0});
      @(posedge clk); #1;
      rst_n = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      check("fetch_after_reset", got_word(), exp_word(0, 1'b0, zero, opcode));
      @(posedge clk); #1;

      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 6))
            0: op = LW;  1: op = SW;  2: op = RT;  3: op = BEQ;
            4: op = ADDI; 5: op = JMP;
            default: begin
               op = 6'($urandom);
               while (is_legal(op)) op = 6'($urandom);
            end
         endcase
         run_instr(op, $urandom_range(0, 1) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   c, d, il, p, r);
         check_int("rand_done", d, is_legal(op) ? 1 : 0);
      end
      @(negedge clk);
      check_int("final_state", int'(state), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
